// File: rtl/interpol_seq.sv
// Frame sequencer for the 16-point complex interpolation core: collects and zero-pads
// a frame, presents it to the core, waits a settle time, captures and streams results.
module interpol_seq #(
    parameter int N      = 16,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       cfg_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [127:0]     s_data,
    input  logic             s_last,
    output logic [N*128-1:0] core_xin,
    input  logic [N*128-1:0] core_xout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [127:0]     m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int AW = $clog2(N);
    localparam int IW = AW + 1;
    localparam int CW = 4;

    localparam logic [IW-1:0] LAST_IDX    = IW'(N - 1);
    localparam logic [IW-1:0] N_IDX       = IW'(N);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [4:0]    N_LEN       = 5'(N);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   wr_idx_reg, wr_idx_next;
    logic [IW-1:0]   rd_idx_reg, rd_idx_next;
    logic [4:0]      len_reg, len_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;

    logic            buf_we;
    logic [127:0]    buf_wdata;
    logic            cap_en;
    logic [IW-1:0]   wr_inc;
    logic [IW-1:0]   len_last;
    logic            len_ok;
    logic [N*128-1:0] obuf_flat;

    assign wr_inc   = wr_idx_reg + 1'b1;
    assign len_last = IW'(len_reg - 5'd1);
    assign len_ok   = (cfg_len != 5'd0) && (cfg_len <= N_LEN);

    assign done = done_reg;
    assign err  = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
            len_reg    <= '0;
            cnt_reg    <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wr_idx_reg <= wr_idx_next;
            rd_idx_reg <= rd_idx_next;
            len_reg    <= len_next;
            cnt_reg    <= cnt_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        wr_idx_next = wr_idx_reg;
        rd_idx_next = rd_idx_reg;
        len_next    = len_reg;
        cnt_next    = cnt_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;
        buf_we      = 1'b0;
        buf_wdata   = '0;
        cap_en      = 1'b0;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        m_data      = '0;
        busy        = (state_reg != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_next    = cfg_len;
                        wr_idx_next = '0;
                        state_next  = ST_LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    buf_we      = 1'b1;
                    buf_wdata   = s_data;
                    wr_idx_next = wr_inc;
                    if (s_last || (wr_idx_reg == len_last)) begin
                        cnt_next   = '0;
                        state_next = (wr_inc < N_IDX) ? ST_PAD : ST_SETTLE;
                    end
                end
            end
            ST_PAD: begin
                // Zero entries complete the frame: +0.0 real, +0.0 imaginary.
                buf_we      = 1'b1;
                buf_wdata   = '0;
                wr_idx_next = wr_inc;
                if (wr_idx_reg == LAST_IDX) begin
                    cnt_next   = '0;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = ST_CAPTURE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_CAPTURE: begin
                cap_en      = 1'b1;
                rd_idx_next = '0;
                state_next  = ST_DRAIN;
            end
            ST_DRAIN: begin
                m_valid = 1'b1;
                m_data  = obuf_flat[rd_idx_reg[AW-1:0]*128 +: 128];
                m_last  = (rd_idx_reg == LAST_IDX);
                if (m_ready) begin
                    rd_idx_next = rd_idx_reg + 1'b1;
                    if (rd_idx_reg == LAST_IDX) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // One input and one output slot per frame entry; the input slots drive the core directly.
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
        logic [127:0] ibuf_reg;
        logic [127:0] obuf_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ibuf_reg <= '0;
                obuf_reg <= '0;
            end else begin
                if (buf_we && (wr_idx_reg[AW-1:0] == AW'(gi))) begin
                    ibuf_reg <= buf_wdata;
                end
                if (cap_en) begin
                    obuf_reg <= core_xout[gi*128 +: 128];
                end
            end
        end

        assign core_xin[gi*128 +: 128]  = ibuf_reg;
        assign obuf_flat[gi*128 +: 128] = obuf_reg;
    end

endmodule

// File: tb/tb_interpol_seq.sv
// Randomized directed bench for interpol_seq: a frame-level reference model predicts the
// padded frame, the core results, handshake timing and the control pulses.
module tb_interpol_seq;

    localparam int N      = 16;
    localparam int SETTLE = 4;
    localparam int W      = 128;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [4:0]       cfg_len = 5'd0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [127:0]     s_data = '0;
    logic             s_last = 1'b0;
    logic [N*W-1:0]   core_xin;
    logic [N*W-1:0]   core_xout;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [127:0]     m_data;
    logic             m_last;
    logic             busy;
    logic             done;
    logic             err;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    logic [127:0] samp [N];

    always #5 clk = ~clk;

    interpol_seq #(.N(N), .SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_len  (cfg_len),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .core_xin (core_xin),
        .core_xout(core_xout),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Stand-in for the interpolation core: each result mixes an entry with its neighbours.
    function automatic logic [127:0] core_fn(input logic [127:0] a, input logic [127:0] b,
                                             input logic [127:0] c, input int k);
        logic [127:0] salt;
        salt = {4{32'h9E3779B9 * 32'(k + 1)}};
        return a ^ {b[63:0], c[127:64]} ^ salt;
    endfunction

    always_comb begin
        core_xout = '0;
        for (int k = 0; k < N; k++) begin
            core_xout[k*W +: W] = core_fn(core_xin[k*W +: W], core_xin[((k+1)%N)*W +: W],
                                          core_xin[((k+N-1)%N)*W +: W], k);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) samp[k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Runs one frame from the start pulse to the cycle done is expected; on return the bench
    // sits at the negedge in which done should be high (or just after a reset release).
    task automatic run_frame(input int len, input int last_at, input int vprob, input int rprob,
                             input bit busy_start, input int rst_at);
        logic [127:0] frame [N];
        logic [127:0] expo  [N];
        logic [127:0] hold_d;
        logic         hold_l;
        bit           stall;
        int           nsent, sent, got, cyc, fall_cyc, mv_cyc, err_seen;

        nsent = (last_at >= 0 && last_at < len) ? last_at + 1 : len;
        for (int k = 0; k < N; k++) frame[k] = (k < nsent) ? samp[k] : '0;
        for (int k = 0; k < N; k++)
            expo[k] = core_fn(frame[k], frame[(k+1)%N], frame[(k+N-1)%N], k);

        start   = 1'b1;
        cfg_len = 5'(len);
        @(negedge clk);
        start = 1'b0;
        chk("load_busy", busy, 1'b1);
        chk("done_low_after_start", done, 1'b0);

        sent = 0; got = 0; cyc = 0; fall_cyc = -1; mv_cyc = -1; err_seen = 0; stall = 0;
        hold_d = '0; hold_l = 1'b0;
        while (got < N) begin
            if (cyc > 3000) begin
                chk("frame_timeout_outputs", got, N);
                return;
            end
            if (err) err_seen++;
            if (mv_cyc < 0) begin
                chk("s_ready", s_ready, (sent < nsent));
                if (!s_ready && fall_cyc < 0) fall_cyc = cyc;
            end
            if (m_valid) begin
                if (mv_cyc < 0) begin
                    mv_cyc = cyc;
                    if (vprob >= 100) chk("lat_load_to_mvalid", mv_cyc, N + SETTLE + 1);
                    chk("lat_pad_settle", mv_cyc - fall_cyc, (N - nsent) + SETTLE + 1);
                    for (int k = 0; k < N; k++) chk("core_xin_entry", core_xin[k*W +: W], frame[k]);
                end
                if (stall) begin
                    chk("m_data_stable", m_data, hold_d);
                    chk("m_last_stable", m_last, hold_l);
                end
                chk("m_data", m_data, expo[got]);
                chk("m_last", m_last, (got == N - 1));
                if (got == rst_at) begin
                    rst_n = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
                    #1;
                    chk("rst_m_valid", m_valid, 1'b0);
                    chk("rst_busy", busy, 1'b0);
                    chk("rst_s_ready", s_ready, 1'b0);
                    chk("rst_m_data", m_data, '0);
                    for (int k = 0; k < N; k++) chk("rst_core_xin", core_xin[k*W +: W], '0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    return;
                end
                if (busy_start && cyc == mv_cyc) begin
                    start   = 1'b1;
                    cfg_len = 5'd4;
                end
            end
            s_valid = ($urandom_range(99) < vprob);
            s_data  = (sent < nsent) ? samp[sent] : {$urandom, $urandom, $urandom, $urandom};
            s_last  = (sent < nsent) ? (s_valid && sent == last_at) : $urandom_range(1) == 1;
            if (s_valid && s_ready) sent++;
            m_ready = ($urandom_range(99) < rprob);
            stall   = m_valid && !m_ready;
            hold_d  = m_data;
            hold_l  = m_last;
            if (m_valid && m_ready) got++;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("done_pulse", done, 1'b1);
        chk("busy_after_frame", busy, 1'b0);
        chk("m_valid_after_frame", m_valid, 1'b0);
        chk("samples_accepted", sent, nsent);
        chk("no_err_in_frame", err_seen, 0);
        for (int k = 0; k < N; k++) chk("core_xin_hold", core_xin[k*W +: W], frame[k]);
    endtask

    task automatic bad_start(input logic [4:0] len);
        int errs, busy_seen;
        start   = 1'b1;
        cfg_len = len;
        @(negedge clk);
        start = 1'b0;
        errs = 0; busy_seen = 0;
        repeat (4) begin
            if (err) errs++;
            if (busy) busy_seen++;
            @(negedge clk);
        end
        chk("err_pulse_count", errs, 1);
        chk("busy_on_bad_len", busy_seen, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_s_ready", s_ready, 1'b0);
        chk("reset_m_valid", m_valid, 1'b0);
        chk("reset_m_last", m_last, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_m_data", m_data, '0);
        for (int k = 0; k < N; k++) chk("reset_core_xin", core_xin[k*W +: W], '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal 8-sample frame with real = imag = k+1.0.
        for (int k = 0; k < N; k++) samp[k] = '0;
        for (int k = 0; k < 8; k++)
            samp[k] = {$realtobits(real'(k) + 1.0), $realtobits(real'(k) + 1.0)};
        run_frame(8, -1, 100, 100, 1'b0, -1);

        // Full frame, started in the same cycle done pulses.
        fill_random();
        run_frame(16, -1, 100, 100, 1'b0, -1);

        // Early s_last on the 3rd sample, then s_last coinciding with len-1.
        fill_random();
        run_frame(10, 2, 100, 100, 1'b0, -1);
        fill_random();
        run_frame(5, 4, 100, 100, 1'b0, -1);

        // Backpressure on both sides with random lengths and optional early end.
        for (int f = 0; f < 4; f++) begin
            int len, la;
            len = $urandom_range(16, 1);
            la  = ($urandom_range(1) == 1) ? -1 : int'($urandom_range(len - 1));
            fill_random();
            run_frame(len, la, 60, 50, 1'b0, -1);
        end

        // Invalid lengths, then a start pulse during DRAIN.
        @(negedge clk);
        bad_start(5'd0);
        bad_start(5'd17);
        fill_random();
        run_frame(12, -1, 100, 60, 1'b1, -1);

        // Reset at rd_idx = 5, then a clean frame afterwards.
        fill_random();
        run_frame(16, -1, 80, 50, 1'b0, 5);
        fill_random();
        run_frame(7, -1, 70, 50, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/interpol_seq.md
Name: interpol_seq

Overview:
- Sequencer for the combinational 16-point complex interpolation core (`Interpol`).
- Accepts a variable-length stream of complex IEEE-754 double samples over a valid/ready interface and zero-pads the frame to N entries.
- Drives the full frame onto the core input bus, waits a programmable settle time, captures the core output, then streams the N results out over a valid/ready interface.
- Performs no floating-point arithmetic; it moves 64-bit bit patterns only.

Parameters:
- N, 16, frame length; core point count.
- SETTLE, 4, cycles the frame is held on core_xin before the core_xout capture; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- cfg_len  input  5  number of input samples in the frame; legal 1..N; latched on an accepted start.
- s_valid  input  1  input sample valid.
- s_ready  output  1  input sample ready.
- s_data  input  128  input sample; [63:0] real bits, [127:64] imaginary bits.
- s_last  input  1  early end of frame; qualified by s_valid && s_ready.
- core_xin  output  N*128  frame to the core; entry k occupies [k*128+127 : k*128], same real/imag split as s_data.
- core_xout  input  N*128  core result, same layout as core_xin.
- m_valid  output  1  output sample valid.
- m_ready  input  1  output sample ready.
- m_data  output  128  output sample, same layout as s_data.
- m_last  output  1  asserted with output entry N-1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in the cycle after the final output handshake.
- err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (asynchronous on rst_n low):
  - State goes to IDLE.
  - Input buffer, output buffer, core_xin, counters and latched length all clear to 0.
  - s_ready, m_valid, m_last, busy, done and err are all 0; m_data is 0.
- States: IDLE, LOAD, PAD, SETTLE, CAPTURE, DRAIN.
- IDLE:
  - start with 1 <= cfg_len <= N: latch len, clear the write index wr_idx, go to LOAD.
  - start with cfg_len = 0 or cfg_len > N: err = 1 for one cycle, stay in IDLE.
- LOAD:
  - s_ready = 1.
  - Each handshake writes s_data into buffer[wr_idx] and increments wr_idx.
  - Leave after the handshake where wr_idx = len-1, or after any handshake with s_last = 1.
  - Exit goes to PAD if the new wr_idx < N, otherwise to SETTLE.
  - s_valid low inserts wait cycles and does not advance wr_idx.
- PAD:
  - s_ready = 0.
  - Writes 128'h0 (+0.0 real, +0.0 imaginary) into buffer[wr_idx], one entry per cycle.
  - When the written entry is N-1, go to SETTLE.
  - PAD takes N - samples_received cycles.
- core_xin:
  - Continuously reflects the buffer.
  - Stays stable from SETTLE entry until the next accepted start.
- SETTLE:
  - Counts SETTLE cycles, then goes to CAPTURE.
- CAPTURE:
  - One cycle; registers all of core_xout into the output buffer.
  - Clears the read index rd_idx and goes to DRAIN.
- DRAIN:
  - m_valid = 1; m_data = obuf[rd_idx]; m_last = 1 when rd_idx = N-1.
  - m_data and m_last must be held stable while m_valid = 1 and m_ready = 0.
  - On a handshake rd_idx increments.
  - The handshake at rd_idx = N-1 goes to IDLE; done pulses in the following cycle and busy drops at the same time.
- Latency:
  - With no stalls and cfg_len = L < N: first m_valid appears L + (N-L) + SETTLE + 1 cycles after the LOAD-entry cycle.
  - For L = N the PAD term is 0.
- Boundary cases:
  - start while busy: ignored, no err.
  - s_last on the handshake with wr_idx = len-1: identical to a normal end.
  - Samples after the frame ends are not accepted (s_ready = 0).
  - A second start arriving in the same cycle done pulses is accepted; IDLE is already active in that cycle.
  - rst_n low mid-frame (any state): immediate return to reset values; the partial frame is discarded.
  - N-1 in index compares must not overflow; wr_idx and rd_idx are $clog2(N)+1 bits wide.

Test Plan:
- Nominal 8-sample frame:
  - Stimulus: cfg_len = 8; samples k = 0..7 with real = imag = $realtobits(k+1.0); behavioural core model on core_xin/core_xout.
  - Required: core_xin entries 8..15 = 0 and entries 0..7 match the inputs; 16 outputs equal the model results in order; m_last only on the 16th; done one cycle later.
- Full frame:
  - Stimulus: cfg_len = 16.
  - Required: PAD is skipped, SETTLE is entered immediately after the 16th handshake, and first m_valid appears 16 + SETTLE + 1 cycles after LOAD entry.
- Early s_last:
  - Stimulus: cfg_len = 10, with s_last on the 3rd sample.
  - Required: s_ready drops, entries 3..15 are zero, and PAD lasts 13 cycles.
- Backpressure:
  - Stimulus: random s_valid gaps and m_ready toggling 50%.
  - Required: no sample loss or duplication; m_data stable during each stall; output order 0..15.
- Invalid length and start while busy:
  - Stimulus: cfg_len = 0 and cfg_len = 17; then start pulsed during DRAIN.
  - Required: err pulses once for each invalid length with busy staying 0; the start during DRAIN is ignored with no err.
- Reset mid-operation:
  - Stimulus: rst_n asserted at rd_idx = 5 in DRAIN.
  - Required: m_valid = 0, busy = 0, core_xin = 0 with no clock edge needed; the next frame then completes correctly.
